// File: rtl/ram_access_sequencer.sv
// Arbitrates instruction-fetch and data requests onto the shared 8-bit ROM/RAM block.
// Each access takes three cycles: IDLE (grant + address latch), ACCESS (strobe), DONE (ack).
module ram_access_sequencer #(
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_fetchReq,
    input  logic [7:0] i_fetchAddress,
    input  logic       i_fetchImmediate,
    output logic       o_fetchAck,
    input  logic       i_dataReq,
    input  logic [7:0] i_dataAddress,
    input  logic       i_dataWrite,
    input  logic [7:0] i_dataWriteData,
    output logic       o_dataAck,
    output logic [7:0] o_readData,
    output logic       o_busy,
    output logic [7:0] o_ramAddress,
    output logic       o_ramAddressEn,
    output logic [7:0] o_ramWriteData,
    output logic       o_ramWriteEn,
    output logic       o_ramReadDataSelect,
    output logic       o_ramImmediateSelect,
    output logic       o_ramOutEnable,
    input  logic [7:0] i_ramReadData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_DATA_STREAK);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_streak;
    logic [3:0] w_nextStreak;
    logic       r_isData;
    logic       r_write;
    logic       r_imm;
    logic [7:0] r_writeData;
    logic [7:0] r_readData;

    logic       w_fetchWins;
    logic       w_grantFetch;
    logic       w_grantData;
    logic       w_grant;

    // Grants are suppressed while reset is held so every output reads zero during reset.
    always_comb begin
        w_fetchWins  = i_fetchReq && (!i_dataReq || (r_streak == LP_MAX_STREAK));
        w_grantFetch = (r_state == S_IDLE) && !i_reset && w_fetchWins;
        w_grantData  = (r_state == S_IDLE) && !i_reset && i_dataReq && !w_fetchWins;
        w_grant      = w_grantFetch || w_grantData;
    end

    always_comb begin
        w_nextStreak = r_streak;
        if (r_state == S_IDLE) begin
            if (w_grantFetch || !i_fetchReq) begin
                w_nextStreak = 4'd0;
            end else if (w_grantData && (r_streak != LP_MAX_STREAK)) begin
                w_nextStreak = r_streak + 4'd1;
            end
        end
    end

    always_comb begin
        w_nextState = S_IDLE;
        case (r_state)
            S_IDLE:   w_nextState = w_grant ? S_ACCESS : S_IDLE;
            S_ACCESS: w_nextState = S_DONE;
            S_DONE:   w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_streak    <= 4'd0;
            r_isData    <= 1'b0;
            r_write     <= 1'b0;
            r_imm       <= 1'b0;
            r_writeData <= 8'h00;
            r_readData  <= 8'h00;
        end else begin
            r_state  <= w_nextState;
            r_streak <= w_nextStreak;
            if (w_grant) begin
                r_isData    <= w_grantData;
                r_write     <= w_grantData && i_dataWrite;
                r_writeData <= i_dataWriteData;
            end
            // The bank select is only refreshed by fetches so it holds between them.
            if (w_grantFetch) begin
                r_imm <= i_fetchImmediate;
            end
            if ((r_state == S_ACCESS) && !r_write) begin
                r_readData <= i_ramReadData;
            end
        end
    end

    always_comb begin
        o_ramAddressEn      = w_grant;
        o_ramAddress        = 8'h00;
        o_ramWriteEn        = 1'b0;
        o_ramWriteData      = 8'h00;
        o_ramOutEnable      = 1'b0;
        o_ramReadDataSelect = 1'b0;
        o_fetchAck          = 1'b0;
        o_dataAck           = 1'b0;
        if (w_grantData) begin
            o_ramAddress = i_dataAddress;
        end else if (w_grantFetch) begin
            o_ramAddress = i_fetchAddress;
        end
        if (r_state == S_ACCESS) begin
            if (r_write) begin
                o_ramWriteEn   = 1'b1;
                o_ramWriteData = r_writeData;
            end else begin
                o_ramOutEnable      = 1'b1;
                o_ramReadDataSelect = !r_isData;
            end
        end
        if (r_state == S_DONE) begin
            o_fetchAck = !r_isData;
            o_dataAck  = r_isData;
        end
    end

    assign o_busy               = (r_state != S_IDLE);
    assign o_ramImmediateSelect = r_imm;
    assign o_readData           = r_readData;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: behavioural ROM/RAM on the memory side, a vector table,
// hand-written arbitration/reset sequences, and an ack-driven scoreboard.
module tb_ram_access_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_fetchReq;
  logic [7:0] i_fetchAddress;
  logic       i_fetchImmediate;
  logic       o_fetchAck;
  logic       i_dataReq;
  logic [7:0] i_dataAddress;
  logic       i_dataWrite;
  logic [7:0] i_dataWriteData;
  logic       o_dataAck;
  logic [7:0] o_readData;
  logic       o_busy;
  logic [7:0] o_ramAddress;
  logic       o_ramAddressEn;
  logic [7:0] o_ramWriteData;
  logic       o_ramWriteEn;
  logic       o_ramReadDataSelect;
  logic       o_ramImmediateSelect;
  logic       o_ramOutEnable;
  logic [7:0] i_ramReadData;

  ram_access_sequencer #(.MAX_DATA_STREAK(3)) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_fetchReq(i_fetchReq),
    .i_fetchAddress(i_fetchAddress),
    .i_fetchImmediate(i_fetchImmediate),
    .o_fetchAck(o_fetchAck),
    .i_dataReq(i_dataReq),
    .i_dataAddress(i_dataAddress),
    .i_dataWrite(i_dataWrite),
    .i_dataWriteData(i_dataWriteData),
    .o_dataAck(o_dataAck),
    .o_readData(o_readData),
    .o_busy(o_busy),
    .o_ramAddress(o_ramAddress),
    .o_ramAddressEn(o_ramAddressEn),
    .o_ramWriteData(o_ramWriteData),
    .o_ramWriteEn(o_ramWriteEn),
    .o_ramReadDataSelect(o_ramReadDataSelect),
    .o_ramImmediateSelect(o_ramImmediateSelect),
    .o_ramOutEnable(o_ramOutEnable),
    .i_ramReadData(i_ramReadData)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory block model ----------------
  logic [7:0] mem_ram [256];
  logic [7:0] mem_lat;

  always @(posedge clk) if (o_ramAddressEn) mem_lat <= o_ramAddress;
  always @(negedge clk) if (o_ramWriteEn) mem_ram[mem_lat] = o_ramWriteData;

  always_comb begin
    i_ramReadData = 8'hEE;
    if (o_ramOutEnable) begin
      if (o_ramReadDataSelect) i_ramReadData = o_ramImmediateSelect ? (mem_lat ^ 8'h96) : (mem_lat ^ 8'h2C);
      else i_ramReadData = mem_ram[mem_lat];
    end
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] ref_ram [256];
  logic [7:0] m_last;
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (o_fetchAck || o_dataAck) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got fetch=%0b data=%0b expected no ack at %0t", o_fetchAck, o_dataAck, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_port", 32'(o_dataAck), 32'(mon_e[8]));
        check("ack_read_data", 32'(o_readData), 32'(mon_e[7:0]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input logic is_data, input logic wr, input logic imm,
                         input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] exp_rd);
    @(negedge clk);
    i_dataReq        = is_data;
    i_fetchReq       = !is_data;
    i_dataAddress    = addr;
    i_fetchAddress   = addr;
    i_dataWrite      = wr;
    i_dataWriteData  = wdata;
    i_fetchImmediate = imm;
    exp_q.push_back({is_data, exp_rd});
    #1;
    check("idle_addr_en", 32'(o_ramAddressEn), 32'd1);
    check("idle_addr", 32'(o_ramAddress), 32'(addr));
    check("idle_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    #1;
    check("acc_busy", 32'(o_busy), 32'd1);
    check("acc_addr_en", 32'(o_ramAddressEn), 32'd0);
    check("acc_we", 32'(o_ramWriteEn), 32'(is_data && wr));
    check("acc_oe", 32'(o_ramOutEnable), 32'(!(is_data && wr)));
    check("acc_sel", 32'(o_ramReadDataSelect), 32'(!is_data));
    if (!is_data) check("acc_imm_sel", 32'(o_ramImmediateSelect), 32'(imm));
    if (is_data && wr) check("acc_wdata", 32'(o_ramWriteData), 32'(wdata));
    @(negedge clk);
    #1;
    check("done_fetch_ack", 32'(o_fetchAck), 32'(!is_data));
    check("done_data_ack", 32'(o_dataAck), 32'(is_data));
    check("done_strobes", 32'({o_ramWriteEn, o_ramOutEnable, o_ramAddressEn}), 32'd0);
    i_dataReq  = 1'b0;
    i_fetchReq = 1'b0;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({o_busy, o_ramAddressEn, o_ramAddress, o_ramWriteEn, o_ramOutEnable,
                o_ramReadDataSelect, o_ramImmediateSelect, o_fetchAck, o_dataAck})
         | 32'({o_ramWriteData, o_readData});
  endfunction

  typedef struct {
    logic       is_data;
    logic       wr;
    logic       imm;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[11];
  logic t3_d[8];

  initial begin
    // {is_data, wr, imm, addr, wdata, expected o_readData at ack}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h42, 8'hA5, 8'h3C};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h42, 8'h00, 8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h69};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h69};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h00, 8'h16};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 8'h22};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h22};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h01};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 8'h1F};
    t3_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) begin
      mem_ram[i] = 8'(i) ^ 8'h55;
      ref_ram[i] = 8'(i) ^ 8'h55;
    end
    n_vec = 0;
    n_err = 0;
    m_last = 8'h00;
    i_reset = 1'b1;
    i_fetchReq = 1'b0;
    i_fetchAddress = 8'h00;
    i_fetchImmediate = 1'b0;
    i_dataReq = 1'b0;
    i_dataAddress = 8'h00;
    i_dataWrite = 1'b0;
    i_dataWriteData = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].is_data, vecs[i].wr, vecs[i].imm, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
      if (vecs[i].is_data && vecs[i].wr) ref_ram[vecs[i].addr] = vecs[i].wdata;
      else m_last = vecs[i].exp_rd;
    end

    // Both requesters held: D,D,D,F,D,D,D,F with one grant every third cycle
    @(negedge clk);
    i_dataReq = 1'b1;
    i_dataWrite = 1'b0;
    i_dataAddress = 8'h20;
    i_fetchReq = 1'b1;
    i_fetchAddress = 8'h05;
    i_fetchImmediate = 1'b0;
    for (int g = 0; g < 8; g++) exp_q.push_back(t3_d[g] ? {1'b1, ref_ram[8'h20]} : {1'b0, 8'h29});
    for (int g = 0; g < 8; g++) begin
      #1;
      check("t3_grant_en", 32'(o_ramAddressEn), 32'd1);
      check("t3_grant_addr", 32'(o_ramAddress), t3_d[g] ? 32'h20 : 32'h05);
      @(negedge clk);
      #1;
      check("t3_no_grant_in_access", 32'(o_ramAddressEn), 32'd0);
      @(negedge clk);
      #1;
      check("t6_no_grant_in_done", 32'(o_ramAddressEn), 32'd0);
      @(negedge clk);
    end
    i_dataReq = 1'b0;
    i_fetchReq = 1'b0;
    m_last = 8'h29;

    // Reset during the ACCESS cycle of a store, then re-grant of the held request
    @(negedge clk);
    i_dataReq = 1'b1;
    i_dataWrite = 1'b1;
    i_dataAddress = 8'h9A;
    i_dataWriteData = 8'hC7;
    #1;
    check("t5_grant", 32'(o_ramAddressEn), 32'd1);
    @(negedge clk);
    #1;
    check("t5_access_we", 32'(o_ramWriteEn), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    check("t5_reset_outputs", all_outputs(), 32'd0);
    i_reset = 1'b0;
    m_last = 8'h00;
    ref_ram[8'h9A] = 8'hC7;
    exp_q.push_back({1'b1, 8'h00});
    #1;
    check("t5_regrant", 32'(o_ramAddressEn), 32'd1);
    check("t5_regrant_addr", 32'(o_ramAddress), 32'h9A);
    @(negedge clk);
    #1;
    check("t5_access_we2", 32'(o_ramWriteEn), 32'd1);
    check("t5_access_oe2", 32'(o_ramOutEnable), 32'd0);
    @(negedge clk);
    #1;
    check("t5_done_ack", 32'(o_dataAck), 32'd1);
    i_dataReq = 1'b0;

    // Random mix of fetches, loads and stores against the reference memory
    for (int i = 0; i < 16; i++) begin
      int unsigned kind;
      logic [7:0] a;
      logic [7:0] d;
      logic imm;
      logic [7:0] e;
      kind = $urandom_range(0, 2);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      imm = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        e = imm ? (a ^ 8'h96) : (a ^ 8'h2C);
        run_txn(1'b0, 1'b0, imm, a, d, e);
        m_last = e;
      end else if (kind == 1) begin
        e = ref_ram[a];
        run_txn(1'b1, 1'b0, 1'b0, a, d, e);
        m_last = e;
      end else begin
        run_txn(1'b1, 1'b1, 1'b0, a, d, m_last);
        ref_ram[a] = d;
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
